axis_deadlock_detector: RTL and testbench
=========================================

Name: axis_deadlock_detector

Overview:
- Per-kernel deadlock decision stage. It sits directly downstream of the kernel monitor top, which gathers AXIS-stream blocking, instance-blocking and instance-idle signals from the flashattn pipeline sub-instances.
- Qualifies those raw signals over time and asserts a sticky block flag once the kernel stays in the same blocked configuration for a programmable number of cycles.
- Latches a snapshot of which channels caused the block, for the simulation deadlock report.

Parameters:
- N_AXIS, 4, number of AXIS channel blocking inputs.
- N_IDLE, 4, number of instance idle inputs.
- N_INST, 1, number of instance (non-AXIS) blocking inputs.
- THRESHOLD, 1024, consecutive stable-stuck cycles needed to declare deadlock (>=2).
- CNT_W, 16, width of the stuck-cycle counter (2^CNT_W > THRESHOLD).

Ports:
- kernel_monitor_clock  in  1  single clock domain.
- kernel_monitor_reset  in  1  asynchronous, active-low reset.
- axis_block_sigs  in  N_AXIS  1 = that AXIS channel is stalled on its TDATA handshake.
- inst_idle_sigs  in  N_IDLE  1 = that instance is idle.
- inst_block_sigs  in  N_INST  1 = that instance is blocked on a non-AXIS resource.
- block  out  1  sticky deadlock flag.
- axis_snapshot  out  N_AXIS  axis_block_sigs value latched when block rose.
- inst_snapshot  out  N_INST  inst_block_sigs value latched when block rose.
- stuck_cycles  out  CNT_W  current consecutive stable-stuck count.

Behaviour:
- Reset (kernel_monitor_reset low, async): state=RUN, block=0, axis_snapshot=0, inst_snapshot=0, stuck_cycles=0, sig_q=0.
- Inputs are registered once: sig_q = {axis_block_sigs, inst_block_sigs}; idle_q = inst_idle_sigs. All decisions use registered values.
- any_blk = |sig_q.
- all_idle = &idle_q.
- stable = (sig_q == previous sig_q).
- States:
  - RUN: stuck_cycles=0. Go to SUSPECT when any_blk && !all_idle.
  - SUSPECT: while any_blk && !all_idle && stable, increment stuck_cycles (saturates at all-ones).
    - Any change in sig_q (including a different nonzero pattern): restart at stuck_cycles=1 and stay in SUSPECT.
    - any_blk==0 or all_idle==1: go to RUN, counter=0.
    - When stuck_cycles reaches THRESHOLD-1 and the condition still holds: go to BLOCKED on the next edge.
  - BLOCKED: block=1. Snapshots are captured from sig_q in the same cycle block rises. All three outputs hold until reset; input changes are ignored.
- Latency: a constant nonzero pattern applied at cycle t (with not-all-idle) raises block at t+THRESHOLD+1 (1 input register plus THRESHOLD counting cycles).
- Simultaneous events:
  - all_idle wins over any_blk; a kernel that is blocked but fully idle is finished, not deadlocked.
  - A pattern change on the exact threshold cycle restarts the count; block does not rise.
- Reset mid-operation: immediate return to reset values, including from BLOCKED.
- stuck_cycles is never compared wider than CNT_W; it saturates and never wraps.

Optional Feature:
- Macro: AXIS_DEADLOCK_REPORT_EN.
- Defined: on the cycle block rises, the simulation prints a report with the sim time, the index of every set bit in axis_snapshot and inst_snapshot, and THRESHOLD. It also drives a per-channel first-block-time array, readable hierarchically, holding the cycle at which each channel's bit last went high before BLOCKED.
- Undefined: no report code and no time array; port behaviour is identical.

Decomposition:
- Shared package deadlock_mon_pkg holds:
  - state enum (RUN, SUSPECT, BLOCKED)
  - default THRESHOLD constant
  - CNT_W default
  - a function computing the saturating increment
- One natural sub-module: stuck_counter (saturating counter with clear/restart/enable and an at-threshold compare output), instantiated once.

Test Plan:
- Reset, then hold all inputs 0 for 2000 cycles -> block=0, stuck_cycles=0 throughout, state RUN.
- THRESHOLD=16; axis_block_sigs=4'b0010, idle=4'b0000 held from cycle 10 -> block rises at cycle 27; axis_snapshot=4'b0010, inst_snapshot=0.
- THRESHOLD=16; axis=4'b0001 for 10 cycles, then 4'b0011 held -> count restarts at 1; block rises 16 cycles after the change; snapshot=4'b0011.
- THRESHOLD=16; axis=4'b1000 held, idle=4'b1111 -> block stays 0 and stuck_cycles stays 0. Then drop idle to 4'b0111 -> block rises after THRESHOLD+1 cycles.
- THRESHOLD=16; inst_block_sigs=1 only, pattern drops to 0 at stuck_cycles=15 -> back to RUN, block=0. Reapply and hold -> block=1.
- In BLOCKED, toggle all inputs randomly for 100 cycles -> block and snapshots unchanged. Assert kernel_monitor_reset low asynchronously mid-cycle -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/deadlock_mon_pkg.sv
// -----------------------------------------------------------------------------
// deadlock_mon_pkg
// Shared definitions for the kernel deadlock decision stage:
//   - state_e        : detector state (RUN, SUSPECT, BLOCKED)
//   - DEF_THRESHOLD  : default number of stable-stuck cycles before deadlock
//   - DEF_CNT_W      : default stuck-cycle counter width
//   - sat_inc()      : saturating increment for counters up to 32 bits wide
// -----------------------------------------------------------------------------
package deadlock_mon_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_BLOCKED = 2'd2
    } state_e;

    localparam int unsigned DEF_THRESHOLD = 32'd1024;
    localparam int unsigned DEF_CNT_W     = 32'd16;

    // Increment val, clamping at the all-ones value of a 'width'-bit counter.
    // Works on a 32-bit carrier so any counter up to 32 bits can share it.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input int unsigned width);
        logic [32:0] w_lim;
        logic [31:0] w_max;
        w_lim = 33'd1 << width;
        w_max = w_lim[31:0] - 32'd1;
        if (val >= w_max) begin
            sat_inc = w_max;
        end else begin
            sat_inc = val + 32'd1;
        end
    endfunction

endpackage

// File: rtl/stuck_counter.sv
// -----------------------------------------------------------------------------
// stuck_counter
// Saturating stuck-cycle counter with clear / restart / enable controls.
// Priority: clear (to 0) > restart (to 1) > enable (saturating +1).
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_clr, i_restart, i_en   counter controls
//   o_cnt     [CNT_W]        current count (registered)
//   o_at_thr                 count equals THRESHOLD-1
// -----------------------------------------------------------------------------
module stuck_counter
    import deadlock_mon_pkg::*;
#(
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned THRESHOLD = DEF_THRESHOLD
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_restart,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_at_thr
);

    localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(THRESHOLD - 32'd1);

    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      w_inc;

    assign w_inc = sat_inc(32'(r_cnt), CNT_W);

    generate
        if (CNT_W < 32) begin : g_hi
            logic w_unused_hi;
            assign w_unused_hi = |w_inc[31:CNT_W];
        end
    endgenerate

    // Count register: clear, restart at one, or saturating increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_restart) begin
            r_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (i_en) begin
            r_cnt <= w_inc[CNT_W-1:0];
        end
    end

    assign o_cnt    = r_cnt;
    assign o_at_thr = (r_cnt == THR_M1);

endmodule

// File: rtl/axis_deadlock_detector.sv
// -----------------------------------------------------------------------------
// axis_deadlock_detector
// Per-kernel deadlock decision stage. Registers the raw AXIS-blocking,
// instance-blocking and instance-idle signals, counts consecutive cycles in
// which the same non-zero blocking pattern persists while the kernel is not
// fully idle, and raises a sticky block flag after THRESHOLD such cycles,
// latching which channels were blocked.
// Ports:
//   kernel_monitor_clock          clock
//   kernel_monitor_reset          asynchronous active-low reset
//   axis_block_sigs [N_AXIS]      1 = AXIS channel stalled on TDATA
//   inst_idle_sigs  [N_IDLE]      1 = instance idle
//   inst_block_sigs [N_INST]      1 = instance blocked on non-AXIS resource
//   block                         sticky deadlock flag
//   axis_snapshot   [N_AXIS]      AXIS pattern when block rose
//   inst_snapshot   [N_INST]      instance pattern when block rose
//   stuck_cycles    [CNT_W]       current consecutive stable-stuck count
// Optional: define AXIS_DEADLOCK_REPORT_EN for a simulation report when block
// rises and a hierarchically readable per-channel first-block-time array.
// -----------------------------------------------------------------------------
module axis_deadlock_detector
    import deadlock_mon_pkg::*;
#(
    parameter int unsigned N_AXIS    = 32'd4,
    parameter int unsigned N_IDLE    = 32'd4,
    parameter int unsigned N_INST    = 32'd1,
    parameter int unsigned THRESHOLD = DEF_THRESHOLD,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic              kernel_monitor_clock,
    input  logic              kernel_monitor_reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_IDLE-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    output logic              block,
    output logic [N_AXIS-1:0] axis_snapshot,
    output logic [N_INST-1:0] inst_snapshot,
    output logic [CNT_W-1:0]  stuck_cycles
);

    localparam int unsigned SIG_W = N_AXIS + N_INST;

    logic [SIG_W-1:0]  r_sig_q;
    logic [SIG_W-1:0]  r_sig_prev;
    logic [N_IDLE-1:0] r_idle_q;
    state_e            r_state;
    logic              r_block;
    logic [N_AXIS-1:0] r_axis_snap;
    logic [N_INST-1:0] r_inst_snap;

    logic   w_any_blk;
    logic   w_all_idle;
    logic   w_stable;
    logic   w_cond;
    logic   w_at_thr;
    logic   w_clr;
    logic   w_restart;
    logic   w_en;
    logic   w_go_blk;
    state_e w_state_nxt;

    // Input register stage; r_sig_prev gives the pattern one cycle older.
    always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
        if (!kernel_monitor_reset) begin
            r_sig_q    <= {SIG_W{1'b0}};
            r_sig_prev <= {SIG_W{1'b0}};
            r_idle_q   <= {N_IDLE{1'b0}};
        end else begin
            r_sig_q    <= {axis_block_sigs, inst_block_sigs};
            r_sig_prev <= r_sig_q;
            r_idle_q   <= inst_idle_sigs;
        end
    end

    assign w_any_blk  = |r_sig_q;
    assign w_all_idle = &r_idle_q;
    assign w_stable   = (r_sig_q == r_sig_prev);
    // A fully idle kernel has finished, so idle overrides blocking.
    assign w_cond     = w_any_blk && !w_all_idle;

    // Next-state and counter control. A pattern change is checked before the
    // threshold compare so a change on the threshold cycle restarts the count.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_restart   = 1'b0;
        w_en        = 1'b0;
        w_go_blk    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_cond) begin
                    w_state_nxt = ST_SUSPECT;
                    w_restart   = 1'b1;
                end else begin
                    w_clr       = 1'b1;
                end
            end
            ST_SUSPECT: begin
                if (!w_cond) begin
                    w_state_nxt = ST_RUN;
                    w_clr       = 1'b1;
                end else if (!w_stable) begin
                    w_restart   = 1'b1;
                end else if (w_at_thr) begin
                    w_en        = 1'b1;
                    w_go_blk    = 1'b1;
                    w_state_nxt = ST_BLOCKED;
                end else begin
                    w_en        = 1'b1;
                end
            end
            ST_BLOCKED: begin
                w_state_nxt = ST_BLOCKED;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_clr       = 1'b1;
            end
        endcase
    end

    // State, sticky flag and snapshot capture on the cycle block rises.
    always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
        if (!kernel_monitor_reset) begin
            r_state     <= ST_RUN;
            r_block     <= 1'b0;
            r_axis_snap <= {N_AXIS{1'b0}};
            r_inst_snap <= {N_INST{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_go_blk) begin
                r_block     <= 1'b1;
                r_axis_snap <= r_sig_q[SIG_W-1:N_INST];
                r_inst_snap <= r_sig_q[N_INST-1:0];
            end
        end
    end

    stuck_counter #(
        .CNT_W     (CNT_W),
        .THRESHOLD (THRESHOLD)
    ) u_stuck_counter (
        .i_clk     (kernel_monitor_clock),
        .i_rst_n   (kernel_monitor_reset),
        .i_clr     (w_clr),
        .i_restart (w_restart),
        .i_en      (w_en),
        .o_cnt     (stuck_cycles),
        .o_at_thr  (w_at_thr)
    );

    assign block         = r_block;
    assign axis_snapshot = r_axis_snap;
    assign inst_snapshot = r_inst_snap;

`ifdef AXIS_DEADLOCK_REPORT_EN
    // Indices [N_INST-1:0] are instance channels, above them AXIS channels.
    longint unsigned r_cycle;
    longint unsigned r_first_blk_time [SIG_W];

    // Cycle counter and per-channel time of the latest rising blocking bit.
    always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
        if (!kernel_monitor_reset) begin
            r_cycle <= 64'd0;
            for (int i = 0; i < int'(SIG_W); i++) begin
                r_first_blk_time[i] <= 64'd0;
            end
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (r_state != ST_BLOCKED) begin
                for (int i = 0; i < int'(SIG_W); i++) begin
                    if (r_sig_q[i] && !r_sig_prev[i]) begin
                        r_first_blk_time[i] <= r_cycle;
                    end
                end
            end
        end
    end

    // Deadlock report printed on the edge that raises block.
    always_ff @(posedge kernel_monitor_clock) begin
        if (kernel_monitor_reset && w_go_blk) begin
            $display("[%0t] axis_deadlock_detector: deadlock declared, THRESHOLD=%0d",
                     $time, THRESHOLD);
            for (int i = 0; i < int'(N_AXIS); i++) begin
                if (r_sig_q[N_INST + i]) begin
                    $display("    axis channel %0d blocked", i);
                end
            end
            for (int i = 0; i < int'(N_INST); i++) begin
                if (r_sig_q[i]) begin
                    $display("    instance channel %0d blocked", i);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_deadlock_detector.sv
// -----------------------------------------------------------------------------
// tb_axis_deadlock_detector
// Directed-vector bench with a scoreboard queue: each stimulus step pushes the
// outputs expected after its clock edge; a monitor on the falling edge pops
// and compares. THRESHOLD is 16 throughout.
// -----------------------------------------------------------------------------
module tb_axis_deadlock_detector;

    localparam int unsigned TH = 32'd16;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic [3:0]  axis_s = 4'd0;
    logic [3:0]  idle_s = 4'd0;
    logic [0:0]  inst_s = 1'b0;
    logic        blk;
    logic [3:0]  asnap;
    logic [0:0]  isnap;
    logic [15:0] stk;

    always #5 clk = ~clk;

    axis_deadlock_detector #(
        .N_AXIS    (4),
        .N_IDLE    (4),
        .N_INST    (1),
        .THRESHOLD (TH),
        .CNT_W     (16)
    ) dut (
        .kernel_monitor_clock (clk),
        .kernel_monitor_reset (rst_n),
        .axis_block_sigs      (axis_s),
        .inst_idle_sigs       (idle_s),
        .inst_block_sigs      (inst_s),
        .block                (blk),
        .axis_snapshot        (asnap),
        .inst_snapshot        (isnap),
        .stuck_cycles         (stk)
    );

    typedef struct {
        logic       eb;
        logic [3:0] eas;
        logic       eis;
        int         estk;
        bit         cs;
        string      nm;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(string nm, string fld, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h at %0t", nm, fld, act, req, $time);
        end
    endfunction

    // Apply inputs, clock once, then queue the outputs expected after that edge.
    task automatic step(input logic [3:0] ax, input logic [3:0] id, input logic ib,
                        input logic eb, input logic [3:0] eas, input logic eis,
                        input int estk, input bit cs, input string nm);
        exp_t e;
        axis_s = ax;
        idle_s = id;
        inst_s = ib;
        @(posedge clk);
        #1;
        e.eb   = eb;
        e.eas  = eas;
        e.eis  = eis;
        e.estk = estk;
        e.cs   = cs;
        e.nm   = nm;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n  = 1'b0;
        axis_s = 4'd0;
        idle_s = 4'd0;
        inst_s = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: compare registered outputs on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            chk(m_e.nm, "block", {31'd0, blk}, {31'd0, m_e.eb});
            chk(m_e.nm, "axis_snapshot", {28'd0, asnap}, {28'd0, m_e.eas});
            chk(m_e.nm, "inst_snapshot", {31'd0, isnap}, {31'd0, m_e.eis});
            if (m_e.cs) begin
                chk(m_e.nm, "stuck_cycles", {16'd0, stk}, 32'(m_e.estk));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("reset", "block", {31'd0, blk}, 32'd0);
        chk("reset", "axis_snapshot", {28'd0, asnap}, 32'd0);
        chk("reset", "inst_snapshot", {31'd0, isnap}, 32'd0);
        chk("reset", "stuck_cycles", {16'd0, stk}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All inputs low: stays in RUN with a zero count.
        for (int j = 0; j < 2000; j++)
            step(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 0, 1'b1, "idle_run");

        // Constant single-channel pattern: count 0..15, block after 17 edges.
        do_reset();
        for (int j = 0; j < 21; j++)
            step(4'b0010, 4'b0000, 1'b0, (j >= 16), (j >= 16) ? 4'b0010 : 4'b0000, 1'b0,
                 j, (j < 16), "single_axis");

        // Pattern change mid-count restarts at 1.
        do_reset();
        for (int j = 0; j < 10; j++)
            step(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, j, 1'b1, "pre_change");
        for (int c = 0; c < 20; c++)
            step(4'b0011, 4'b0000, 1'b0, (c >= 16), (c >= 16) ? 4'b0011 : 4'b0000, 1'b0,
                 (c == 0) ? 10 : c, (c < 16), "post_change");

        // Fully idle kernel is never suspect; releasing one idle bit arms it.
        do_reset();
        for (int j = 0; j < 30; j++)
            step(4'b1000, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 0, 1'b1, "all_idle");
        for (int d = 0; d < 20; d++)
            step(4'b1000, 4'b0111, 1'b0, (d >= 16), (d >= 16) ? 4'b1000 : 4'b0000, 1'b0,
                 d, (d < 16), "idle_drop");

        // Instance-only block removed as the count reaches 15: back to RUN.
        do_reset();
        for (int j = 0; j < 15; j++)
            step(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, j, 1'b1, "inst_ramp");
        step(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 15, 1'b1, "inst_drop");
        for (int j = 0; j < 5; j++)
            step(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 0, 1'b1, "inst_run");
        for (int j = 0; j < 20; j++)
            step(4'b0000, 4'b0000, 1'b1, (j >= 16), 4'b0000, (j >= 16),
                 j, (j < 16), "inst_reapply");

        // Different nonzero pattern on the threshold cycle restarts the count.
        do_reset();
        for (int j = 0; j < 15; j++)
            step(4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, j, 1'b1, "thr_ramp");
        for (int m = 0; m < 18; m++)
            step(4'b0110, 4'b0000, 1'b0, (m >= 16), (m >= 16) ? 4'b0110 : 4'b0000, 1'b0,
                 (m == 0) ? 15 : m, (m < 16), "thr_change");

        // BLOCKED ignores input activity.
        for (int j = 0; j < 100; j++)
            step(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
                 1'b1, 4'b0110, 1'b0, 0, 1'b0, "blocked_hold");

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        @(negedge clk);
        #1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst", "block", {31'd0, blk}, 32'd0);
        chk("async_rst", "axis_snapshot", {28'd0, asnap}, 32'd0);
        chk("async_rst", "inst_snapshot", {31'd0, isnap}, 32'd0);
        chk("async_rst", "stuck_cycles", {16'd0, stk}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++)
            step(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 0, 1'b1, "after_rst");

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
